// File: rtl/cordic_iter_engine.sv
// Iterative circular CORDIC engine: one micro-rotation per clock, rotation or vectoring mode.
// Arctangent constants come from an external ROM addressed by atan_idx; the CORDIC gain is not removed.
module cordic_iter_engine #(
  parameter int unsigned BIT_WIDTH  = 64,
  parameter int unsigned ITERATIONS = 32,
  parameter int unsigned IDX_W      = $clog2(ITERATIONS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode_bit,
  input  logic [IDX_W-1:0]     iter_limit,
  input  logic [BIT_WIDTH-1:0] x_in,
  input  logic [BIT_WIDTH-1:0] y_in,
  input  logic [BIT_WIDTH-1:0] z_in,
  output logic [IDX_W-1:0]     atan_idx,
  input  logic [BIT_WIDTH-1:0] atan_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] x_out,
  output logic [BIT_WIDTH-1:0] y_out,
  output logic [BIT_WIDTH-1:0] z_out,
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] MAX_ITER = IDX_W'(ITERATIONS);

  logic [1:0]                  state_q;
  logic [IDX_W-1:0]            iter_q;
  logic [IDX_W-1:0]            limit_q;
  logic                        mode_q;
  logic signed [BIT_WIDTH-1:0] x_q, y_q, z_q;

  logic [IDX_W-1:0]            limit_sel;
  logic                        dir;
  logic                        last_iter;
  logic signed [BIT_WIDTH-1:0] x_sh, y_sh;
  logic signed [BIT_WIDTH-1:0] x_nx, y_nx, z_nx;

  always_comb begin
    limit_sel = iter_limit;
    if ((iter_limit == '0) || (iter_limit > MAX_ITER)) begin
      limit_sel = MAX_ITER;
    end
  end

  // Rotation drives z toward 0, vectoring drives y toward 0.
  always_comb begin
    dir       = mode_q ? ~y_q[BIT_WIDTH-1] : z_q[BIT_WIDTH-1];
    x_sh      = x_q >>> iter_q;
    y_sh      = y_q >>> iter_q;
    last_iter = (iter_q + IDX_W'(1)) == limit_q;
    if (dir) begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + $signed(atan_val);
    end else begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - $signed(atan_val);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= $signed(x_in);
            y_q     <= $signed(y_in);
            z_q     <= $signed(z_in);
            mode_q  <= mode_bit;
            limit_q <= limit_sel;
            iter_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q    <= x_nx;
          y_q    <= y_nx;
          z_q    <= z_nx;
          iter_q <= iter_q + IDX_W'(1);
          if (last_iter) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign atan_idx  = (state_q == RUN) ? iter_q : '0;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: Q3.12 16-bit engine with an atan ROM, plus a small
// 7-bit instance for iteration-limit clamping and wrap-around shifts.
module tb_cordic_iter_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, mode_bit, out_valid, out_ready, busy;
  logic [3:0]  iter_limit, atan_idx;
  logic [15:0] x_in, y_in, z_in, atan_val, x_out, y_out, z_out;

  logic       in_valid2, in_ready2, mode_bit2, out_valid2, out_ready2, busy2;
  logic [2:0] iter_limit2, atan_idx2;
  logic [6:0] x_in2, y_in2, z_in2, atan_val2, x_out2, y_out2, z_out2;

  logic [15:0] atan_tab [16] = '{16'd3217, 16'd1899, 16'd1003, 16'd509, 16'd256, 16'd128,
                                 16'd64, 16'd32, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1, 16'd0,
                                 16'd0, 16'd0};

  always #5 clk = ~clk;
  assign atan_val  = atan_tab[atan_idx];
  assign atan_val2 = '0;

  cordic_iter_engine #(.BIT_WIDTH(16), .ITERATIONS(15), .IDX_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode_bit(mode_bit),
    .iter_limit(iter_limit), .x_in(x_in), .y_in(y_in), .z_in(z_in), .atan_idx(atan_idx),
    .atan_val(atan_val), .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
    .y_out(y_out), .z_out(z_out), .busy(busy)
  );

  cordic_iter_engine #(.BIT_WIDTH(7), .ITERATIONS(6), .IDX_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .mode_bit(mode_bit2),
    .iter_limit(iter_limit2), .x_in(x_in2), .y_in(y_in2), .z_in(z_in2), .atan_idx(atan_idx2),
    .atan_val(atan_val2), .out_valid(out_valid2), .out_ready(out_ready2), .x_out(x_out2),
    .y_out(y_out2), .z_out(z_out2), .busy(busy2)
  );

  typedef struct {
    int x; int y; int z;
    int tx; int ty; int tz;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_exp = 0;
  int   n_out = 0;
  int   cyc = 0;

  task automatic chk(input string name, input int act, input int req, input int tol);
    int d;
    n_chk++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, req, tol, $time);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int s7(input logic [6:0] v);
    return int'($signed(v));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: latency, atan_idx sequence and result checking against the scoreboard.
  initial begin : monitor
    int   acc_cyc = 0;
    int   lat = 0;
    bit   seen_valid = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (in_valid && in_ready) begin
          acc_cyc    = cyc;
          seen_valid = 1'b0;
        end
        if (busy && !out_valid) chk("atan_idx_seq", int'(atan_idx), cyc - acc_cyc - 1, 0);
        if (out_valid && !seen_valid) begin
          seen_valid = 1'b1;
          lat        = cyc - acc_cyc - 1;
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0, 0);
          end else begin
            e = sb.pop_front();
            chk("latency", lat, e.lat, 0);
            chk("x_out", s16(x_out), e.x, e.tx);
            chk("y_out", s16(y_out), e.y, e.ty);
            chk("z_out", s16(z_out), e.z, e.tz);
          end
        end
      end
    end
  end

  task automatic send(input bit mode, input logic [3:0] lim, input int x, input int y,
                      input int z, input bit expect_out, input exp_t e);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1, 0);
    if (expect_out) begin
      sb.push_back(e);
      n_exp++;
    end
    mode_bit   = mode;
    iter_limit = lim;
    x_in       = 16'(x);
    y_in       = 16'(y);
    z_in       = 16'(z);
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (n_out != n_exp && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("outputs_done", n_out, n_exp, 0);
  endtask

  initial begin : stim
    int   cx, cy, cz, w;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode_bit = 1'b0; iter_limit = '0;
    x_in = '0; y_in = '0; z_in = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; mode_bit2 = 1'b0; iter_limit2 = '0;
    x_in2 = '0; y_in2 = '0; z_in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_atan_idx", int'(atan_idx), 0, 0);
    chk("rst_xyz", int'(x_out | y_out | z_out), 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single step, rotation, z negative -> dir=1.
    e = '{x: 150, y: -50, z: 3207, tx: 0, ty: 0, tz: 0, lat: 1};
    send(1'b0, 4'd1, 100, 50, -10, 1'b1, e);
    wait_done();
    // Additions wrap modulo 2^16.
    e = '{x: 0, y: -2, z: -3217, tx: 0, ty: 0, tz: 0, lat: 1};
    send(1'b0, 4'd1, 32767, 32767, 0, 1'b1, e);
    wait_done();
    // Short vectoring run, direction flips each step.
    e = '{x: 1900, y: 50, z: -2321, tx: 0, ty: 0, tz: 0, lat: 3};
    send(1'b1, 4'd3, 1000, -600, 0, 1'b1, e);
    wait_done();

    // Backpressure in DONE.
    out_ready = 1'b0;
    e = '{x: 315, y: 55, z: -818, tx: 0, ty: 0, tz: 0, lat: 2};
    send(1'b0, 4'd2, 200, -30, 500, 1'b1, e);
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_out_valid", int'(out_valid), 1, 0);
    cx = s16(x_out); cy = s16(y_out); cz = s16(z_out);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      x_in = 16'd1; y_in = 16'd2; z_in = 16'd3;
      @(posedge clk); #1;
      chk("bp_x_stable", s16(x_out), cx, 0);
      chk("bp_y_stable", s16(y_out), cy, 0);
      chk("bp_z_stable", s16(z_out), cz, 0);
      chk("bp_in_ready", int'(in_ready), 0, 0);
      chk("bp_busy", int'(busy), 1, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", int'(in_ready), 1, 0);
    chk("release_out_valid", int'(out_valid), 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pulse_not_accepted", int'(busy), 0, 0);

    // Full rotation by pi/4 with iter_limit=0 -> 15 iterations.
    e = '{x: 2896, y: 2896, z: 0, tx: 4, ty: 4, tz: 2, lat: 15};
    send(1'b0, 4'd0, 2487, 0, 3217, 1'b1, e);
    wait_done();
    // Full vectoring of (1,1).
    e = '{x: 9539, y: 0, z: 3217, tx: 6, ty: 2, tz: 2, lat: 15};
    send(1'b1, 4'd15, 4096, 4096, 0, 1'b1, e);
    wait_done();

    // Reset mid-RUN aborts; no output expected.
    send(1'b0, 4'd0, 1000, 0, 500, 1'b0, e);
    w = 0;
    while (atan_idx != 4'd3 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reached_iter3", int'(atan_idx), 3, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", int'(in_ready), 1, 0);
    chk("abort_out_valid", int'(out_valid), 0, 0);
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_x", s16(x_out), 0, 0);
    chk("abort_y", s16(y_out), 0, 0);
    chk("abort_z", s16(z_out), 0, 0);
    e = '{x: 1900, y: 50, z: -2321, tx: 0, ty: 0, tz: 0, lat: 3};
    send(1'b1, 4'd3, 1000, -600, 0, 1'b1, e);
    wait_done();

    // Small instance: iter_limit=7 clamps to 6; y wraps at step 1.
    x_in2 = 7'h40; y_in2 = '0; z_in2 = '0; mode_bit2 = 1'b0; iter_limit2 = 3'd7;
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("small_atan_idx", int'(atan_idx2), k, 0);
      chk("small_not_done", int'(out_valid2), 0, 0);
      @(posedge clk); #1;
    end
    chk("small_out_valid", int'(out_valid2), 1, 0);
    chk("small_x", s7(x_out2), -44, 0);
    chk("small_y", s7(y_out2), 14, 0);
    chk("small_z", s7(z_out2), 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0, 0);
    chk("output_count", n_out, n_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
